// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with pipelined multiply and iterative radix-2 divide
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int ENABLE_M   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            op_5,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int DCW = $clog2(XLEN + 1);
    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nx, acc_state;

    logic accept;
    logic is_m_enc, dec_illegal, dec_mul, dec_div;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_res, alu_res;

    // multiply operand capture (used when the product spans several cycles)
    logic [XLEN-1:0]   m_a, m_b;
    logic [2:0]        m_f3;
    logic [MCW-1:0]    mul_cnt;
    logic [XLEN-1:0]   pa, pb;
    logic [2:0]        pf3;
    logic              p_sa, p_sb;
    logic [2*XLEN-1:0] pa_ext, pb_ext, prod;
    logic [XLEN-1:0]   mul_res;
    logic              mul_done;

    // divider state: restoring division on magnitudes, signs reapplied at the end
    logic            d_signed_in, a_neg_in, b_neg_in, b_zero_in, ovf_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in, spec_res_in;
    logic [XLEN-1:0] d_rem, d_quo, d_div, d_spec_res;
    logic [DCW-1:0]  d_cnt;
    logic            d_special, d_neg_q, d_neg_r, d_is_rem;
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] q_fix, r_fix, div_res;
    logic            div_done;

    assign in_ready  = !rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

    assign is_m_enc    = (alu_op == 2'b10) & op_5 & funct7_0;
    assign dec_illegal = (alu_op == 2'b11) | (is_m_enc & (ENABLE_M == 0));
    assign dec_mul     = is_m_enc & (ENABLE_M != 0) & !funct3[2];
    assign dec_div     = is_m_enc & (ENABLE_M != 0) & funct3[2];

    assign shamt   = src_b[SHW-1:0];
    assign sra_res = $signed(src_a) >>> shamt;

    // single-cycle integer ALU result from the live request fields
    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = src_a + src_b;
            2'b01: alu_res = src_a - src_b;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_res = (op_5 & funct7_5) ? (src_a - src_b) : (src_a + src_b);
                    3'b001:  alu_res = src_a << shamt;
                    3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    3'b011:  alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                    3'b100:  alu_res = src_a ^ src_b;
                    3'b101:  alu_res = funct7_5 ? sra_res : (src_a >> shamt);
                    3'b110:  alu_res = src_a | src_b;
                    default: alu_res = src_a & src_b;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // With a single stage the product must come straight from the request inputs
    assign pa     = (MUL_STAGES == 1) ? src_a  : m_a;
    assign pb     = (MUL_STAGES == 1) ? src_b  : m_b;
    assign pf3    = (MUL_STAGES == 1) ? funct3 : m_f3;
    assign p_sa   = (pf3 == 3'b001) | (pf3 == 3'b010);
    assign p_sb   = (pf3 == 3'b001);
    assign pa_ext = {{XLEN{p_sa & pa[XLEN-1]}}, pa};
    assign pb_ext = {{XLEN{p_sb & pb[XLEN-1]}}, pb};
    assign prod   = pa_ext * pb_ext;
    assign mul_res  = (pf3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign mul_done = (state == S_MUL) & (mul_cnt == MCW'(MUL_STAGES - 1));

    assign d_signed_in = !funct3[0];
    assign a_neg_in    = d_signed_in & src_a[XLEN-1];
    assign b_neg_in    = d_signed_in & src_b[XLEN-1];
    assign mag_a_in    = a_neg_in ? (-src_a) : src_a;
    assign mag_b_in    = b_neg_in ? (-src_b) : src_b;
    assign b_zero_in   = (src_b == '0);
    assign ovf_in      = d_signed_in & (src_a == MIN_VAL) & (src_b == '1);
    assign spec_res_in = b_zero_in ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : MIN_VAL);

    assign shifted  = {d_rem, d_quo[XLEN-1]};
    assign trial    = shifted - {1'b0, d_div};
    assign q_fix    = d_neg_q ? (-d_quo) : d_quo;
    assign r_fix    = d_neg_r ? (-d_rem) : d_rem;
    assign div_res  = d_is_rem ? r_fix : q_fix;
    assign div_done = (state == S_DIV) & (d_special | (d_cnt == DCW'(XLEN)));

    // state entered by a freshly accepted request
    always_comb begin
        acc_state = S_DONE;
        if (dec_mul) begin
            acc_state = (MUL_STAGES > 1) ? S_MUL : S_DONE;
        end else if (dec_div) begin
            acc_state = S_DIV;
        end
    end

    // next-state logic; DONE can hand off directly to a new op
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = acc_state;
            S_MUL:   if (mul_done) state_nx = S_DONE;
            S_DIV:   if (div_done) state_nx = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_nx = acc_state;
                end else if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // operand capture, multiply/divide progress and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            illegal    <= 1'b0;
            m_a        <= '0;
            m_b        <= '0;
            m_f3       <= '0;
            mul_cnt    <= '0;
            d_rem      <= '0;
            d_quo      <= '0;
            d_div      <= '0;
            d_cnt      <= '0;
            d_special  <= 1'b0;
            d_spec_res <= '0;
            d_neg_q    <= 1'b0;
            d_neg_r    <= 1'b0;
            d_is_rem   <= 1'b0;
        end else if (accept) begin
            m_a        <= src_a;
            m_b        <= src_b;
            m_f3       <= funct3;
            mul_cnt    <= MCW'(1);
            d_rem      <= '0;
            d_quo      <= mag_a_in;
            d_div      <= mag_b_in;
            d_cnt      <= '0;
            d_special  <= b_zero_in | ovf_in;
            d_spec_res <= spec_res_in;
            d_neg_q    <= a_neg_in ^ b_neg_in;
            d_neg_r    <= a_neg_in;
            d_is_rem   <= funct3[1];
            illegal    <= dec_illegal;
            if (dec_illegal) begin
                result <= '0;
            end else if (dec_mul) begin
                if (MUL_STAGES == 1) begin
                    result <= mul_res;
                end
            end else if (!dec_div) begin
                result <= alu_res;
            end
        end else if (state == S_MUL) begin
            if (mul_done) begin
                result <= mul_res;
            end else begin
                mul_cnt <= mul_cnt + MCW'(1);
            end
        end else if (state == S_DIV) begin
            if (d_special) begin
                result <= d_spec_res;
            end else if (d_cnt == DCW'(XLEN)) begin
                result <= div_res;
            end else begin
                d_quo <= {d_quo[XLEN-2:0], !trial[XLEN]};
                d_rem <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                d_cnt <= d_cnt + DCW'(1);
            end
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute unit that decodes the ALU control fields and performs the operation itself.
- Covers full RV32I-style ALU ops plus optional M-extension ops:
  - pipelined multiply;
  - iterative radix-2 divide.
- Sits in the EX stage of the multicycle/pipelined core.
- Valid/ready handshakes on both sides; one outstanding operation.

Parameters:
XLEN, 32, datapath width (≥8, power of 2)
MUL_STAGES, 2, multiply latency in cycles (≥1)
ENABLE_M, 1, 1 = decode M ops; 0 = M encodings flagged illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
alu_op  in  2  00 add, 01 sub, 10 R/I decode, 11 reserved
funct3  in  3  instruction funct3
op_5  in  1  opcode bit 5 (1 = R-type)
funct7_5  in  1  funct7 bit 5
funct7_0  in  1  funct7 bit 0 (M-extension select)
src_a  in  XLEN  operand A
src_b  in  XLEN  operand B / immediate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
illegal  out  1  request had an undecodable encoding; qualified by out_valid

Behaviour:
- Accept on the rising edge where in_valid & in_ready. Call that edge E1; "latency N" means out_valid is high after edge EN.
- in_ready = !rst & (state==IDLE | (state==DONE & out_ready)). This allows back-to-back accept in the same cycle a result is consumed.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: accept an ALU/illegal op → DONE; accept a mul op → MUL; accept a div/rem op → DIV.
  - MUL: stays MUL_STAGES-1 cycles, then → DONE.
  - DIV: → DONE after the iterations complete.
  - DONE: out_valid=1; on out_ready, → IDLE, or → the new op's state if a new op is accepted in the same cycle.
- Decode, alu_op=10, non-M (funct3):
  - 000: add; sub iff op_5 & funct7_5.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra iff funct7_5 (R and I).
  - 110: or.
  - 111: and.
  - Shift amount = src_b[log2(XLEN)-1:0].
- Decode, alu_op=00 → add; alu_op=01 → sub (regardless of funct fields).
- M ops: selected when alu_op=10 & op_5 & funct7_0 & ENABLE_M.
  - funct3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
  - Multiply forms the full 2·XLEN product. mul returns the low half; mulh/mulhsu/mulhu return the high half with the appropriate operand signedness.
- Illegal: alu_op=11, or an M encoding with ENABLE_M=0. Result 0, illegal=1, latency 1.
- Latency:
  - ALU ops: 1.
  - Multiply: MUL_STAGES.
  - Divide/remainder: XLEN+2 (load, XLEN restoring iterations on magnitudes, sign fixup).
- Divide special cases, latency 2, iterations skipped:
  - Divide by zero: quotient all-ones; remainder = src_a.
  - Signed overflow (min / −1): quotient = min; remainder = 0.
- Signed divide sign rules: quotient is negative iff operand signs differ and the divisor ≠ 0; remainder takes the sign of the dividend.
- result and illegal are registered and hold stable while out_valid & !out_ready. Operands are captured at accept, so src_a/src_b may change afterwards.
- Reset (any state, including mid-MUL/DIV):
  - Next cycle: state=IDLE, out_valid=0, result=0, illegal=0.
  - The in-flight op is discarded and never produces out_valid.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
- in_valid while in_ready=0 is ignored; the request is not queued.

Test Plan:
1. XLEN=32. alu_op=10, f3=000, op_5=1, f7_5=0, a=5, b=7 → result 0x0000000C, out_valid one cycle after accept. Same with f7_5=1 → 0xFFFFFFFE. Same with op_5=0, f7_5=1 (addi) → 0x0000000C.
2. a=0x80000000, b=4, f3=101: f7_5=1 → 0xF8000000; f7_5=0 → 0x08000000. f3=011, a=1, b=0xFFFFFFFF → 1. f3=010 with the same operands → 0.
3. MUL_STAGES=2, M ops with a=0xFFFFFFFF, b=2: mulh → 0xFFFFFFFF; mulhu → 0x00000001; mul → 0xFFFFFFFE. Each has out_valid exactly 2 cycles after accept.
4. Divide:
   - div a=0xFFFFFFF9, b=2 → 0xFFFFFFFD at latency 34.
   - rem with the same operands → 0xFFFFFFFF.
   - divu by 0 → 0xFFFFFFFF at latency 2.
   - remu a=9, b=0 → 9.
   - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
5. Hold out_ready=0 for 5 cycles after an ALU result → result and out_valid stable, in_ready=0. Then raise out_ready together with a new in_valid (add 1+1) → new op accepted that cycle, next result 2 on the following cycle.
6. Assert rst for 1 cycle, 10 cycles into a div → out_valid=0 and no result is ever produced; in_ready=1 after release. Then alu_op=11 → out_valid after 1 cycle with illegal=1, result=0. With ENABLE_M=0, mul → illegal=1.
